// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the receive-side address filter and the
// TX loopback path: address widths, the broadcast address, the header depth
// buffered before a decision, and the filter state encoding.
package eth_pkg;

    localparam int MAC_ADDR_W = 48;
    localparam logic [MAC_ADDR_W-1:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam int HDR_BYTES = 6;

    typedef enum logic [1:0] {
        HDR,
        PASS,
        FLUSH,
        DROP
    } filt_state_t;

endpackage

// File: rtl/eth_rx_addr_match.sv
// Destination address acceptance policy. Purely combinational so it can be
// evaluated on the same beat that completes the destination field.
module eth_rx_addr_match
    import eth_pkg::*;
(
    input  logic [MAC_ADDR_W-1:0] dest,
    input  logic [MAC_ADDR_W-1:0] local_mac,
    input  logic                  promisc_en,
    input  logic                  bcast_en,
    input  logic                  mcast_en,
    output logic                  match
);

    logic is_unicast_hit;
    logic is_bcast;
    logic is_mcast;

    // Classify the destination and combine with the enables; unicast to the
    // station address is always accepted.
    always_comb begin
        is_unicast_hit = (dest == local_mac);
        is_bcast       = (dest == MAC_BCAST);
        is_mcast       = dest[MAC_ADDR_W-8];
        match          = promisc_en || is_unicast_hit ||
                         (bcast_en && is_bcast) || (mcast_en && is_mcast);
    end

endmodule

// File: rtl/eth_rx_dest_filter.sv
// Receive destination-address filter. Holds the first six bytes of each
// frame, decides on the sixth, then either forwards the frame with a fixed
// six-byte delay (draining the held bytes after tlast) or discards it.
module eth_rx_dest_filter
    import eth_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,

    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    input  logic [47:0]           local_mac,
    input  logic                  promisc_en,
    input  logic                  bcast_en,
    input  logic                  mcast_en,

    output logic [CNT_WIDTH-1:0]  frames_passed,
    output logic [CNT_WIDTH-1:0]  frames_dropped,
    output logic [CNT_WIDTH-1:0]  frames_runt,
    output logic                  overlap_err
);

    filt_state_t     state;
    logic [2:0]      idx;          // header fill index in HDR, drain index in FLUSH
    logic [7:0]      sr [HDR_BYTES];
    logic            tuser_latch;
    logic            ovl_active;   // a frame that started during FLUSH is still open
    logic            ovl_seen;     // overlap already reported for this flush
    logic            drop_silent;  // current DROP discards an overlapping frame
    logic            ovl_next;
    logic            last_hdr;
    logic            last_flush;
    logic [MAC_ADDR_W-1:0] dest;
    logic            addr_hit;

    assign last_hdr   = (idx == 3'(HDR_BYTES - 1));
    assign last_flush = (idx == 3'(HDR_BYTES - 1));
    assign dest       = {sr[0], sr[1], sr[2], sr[3], sr[4], s_axis_tdata};
    // Whether an overlapping frame is still in progress once this cycle ends.
    assign ovl_next   = s_axis_tvalid ? !s_axis_tlast : ovl_active;

    eth_rx_addr_match u_addr_match (
        .dest       (dest),
        .local_mac  (local_mac),
        .promisc_en (promisc_en),
        .bcast_en   (bcast_en),
        .mcast_en   (mcast_en),
        .match      (addr_hit)
    );

    // Byte buffer: filled by index during the header, shifted on every
    // forwarded beat and on every drain cycle. Data only, no reset needed.
    always_ff @(posedge rx_clk) begin
        case (state)
            HDR: begin
                if (s_axis_tvalid) begin
                    for (int i = 0; i < HDR_BYTES; i++) begin
                        if (idx == 3'(i)) sr[i] <= s_axis_tdata;
                    end
                end
            end
            PASS: begin
                if (s_axis_tvalid) begin
                    for (int i = 0; i < HDR_BYTES - 1; i++) sr[i] <= sr[i+1];
                    sr[HDR_BYTES-1] <= s_axis_tdata;
                end
            end
            FLUSH: begin
                for (int i = 0; i < HDR_BYTES - 1; i++) sr[i] <= sr[i+1];
            end
            default: ;
        endcase
    end

    // Filter state machine with registered stream outputs and statistics.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state          <= HDR;
            idx            <= '0;
            tuser_latch    <= 1'b0;
            ovl_active     <= 1'b0;
            ovl_seen       <= 1'b0;
            drop_silent    <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tuser   <= 1'b0;
            frames_passed  <= '0;
            frames_dropped <= '0;
            frames_runt    <= '0;
            overlap_err    <= 1'b0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            overlap_err   <= 1'b0;

            case (state)
                HDR: begin
                    if (s_axis_tvalid) begin
                        if (s_axis_tlast) begin
                            frames_runt <= frames_runt + CNT_WIDTH'(1);
                            idx         <= '0;
                        end else if (last_hdr) begin
                            idx         <= '0;
                            drop_silent <= 1'b0;
                            state       <= addr_hit ? PASS : DROP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end

                PASS: begin
                    if (s_axis_tvalid) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= sr[0];
                        if (s_axis_tlast) begin
                            tuser_latch   <= s_axis_tuser;
                            frames_passed <= frames_passed + CNT_WIDTH'(1);
                            idx           <= '0;
                            ovl_active    <= 1'b0;
                            ovl_seen      <= 1'b0;
                            state         <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= sr[0];
                    if (s_axis_tvalid) begin
                        ovl_active <= !s_axis_tlast;
                        if (!ovl_seen) begin
                            overlap_err <= 1'b1;
                            ovl_seen    <= 1'b1;
                        end
                    end
                    if (last_flush) begin
                        m_axis_tlast <= 1'b1;
                        m_axis_tuser <= tuser_latch;
                        idx          <= '0;
                        drop_silent  <= 1'b1;
                        state        <= ovl_next ? DROP : HDR;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end

                DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        if (!drop_silent) begin
                            frames_dropped <= frames_dropped + CNT_WIDTH'(1);
                        end
                        idx   <= '0;
                        state <= HDR;
                    end
                end

                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_dest_filter.sv
// Directed bench for the receive destination filter. Expected output beats
// (byte, tlast, tuser, edge number) are queued as stimulus is driven and
// popped when the filter emits a beat.
module tb_eth_rx_dest_filter;

    localparam int CW = 32;

    logic          rx_clk = 1'b0;
    logic          rx_rst;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [47:0]   local_mac;
    logic          promisc_en;
    logic          bcast_en;
    logic          mcast_en;
    logic [CW-1:0] frames_passed;
    logic [CW-1:0] frames_dropped;
    logic [CW-1:0] frames_runt;
    logic          overlap_err;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_passed = 0;
    int   exp_dropped = 0;
    int   exp_runt = 0;
    int   ovl_cnt = 0;
    int   exp_ovl = 0;

    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;

    eth_rx_dest_filter #(.CNT_WIDTH(CW)) dut (
        .rx_clk         (rx_clk),
        .rx_rst         (rx_rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .local_mac      (local_mac),
        .promisc_en     (promisc_en),
        .bcast_en       (bcast_en),
        .mcast_en       (mcast_en),
        .frames_passed  (frames_passed),
        .frames_dropped (frames_dropped),
        .frames_runt    (frames_runt),
        .overlap_err    (overlap_err)
    );

    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge rx_clk) begin
        if (rx_rst !== 1'b1) begin
            if (overlap_err === 1'b1) ovl_cnt++;
            if (m_axis_tvalid !== 1'b0) begin
                chk("beat_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_data", 64'(m_axis_tdata), 64'(e.data));
                    chk("out_last", 64'(m_axis_tlast), 64'(e.last));
                    chk("out_user", 64'(m_axis_tuser), 64'(e.user));
                    chk("out_edge", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    // Drive one frame back to back; if pass is set, queue the forwarded
    // stream: byte j-6 on the edge accepting byte j, then six drain beats.
    task automatic send_frame(input logic [47:0] dest, input int len, input logic user,
                              input bit pass, input int abort_at);
        logic [7:0] fr[$];
        exp_t it;
        int   edge_n;
        for (int j = 0; j < len; j++) begin
            if (j < 6) fr.push_back(dest[47-8*j -: 8]);
            else       fr.push_back(8'($urandom_range(0, 255)));
        end
        for (int j = 0; j < len; j++) begin
            if (abort_at >= 0 && j == abort_at) break;
            s_axis_tdata  = fr[j];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (j == len - 1);
            s_axis_tuser  = (j == len - 1) ? user : 1'b0;
            @(posedge rx_clk);
            #1;
            edge_n = cyc;
            if (pass && j >= 6) begin
                it.data = fr[j-6]; it.last = 1'b0; it.user = 1'b0; it.cyc = edge_n;
                q.push_back(it);
            end
            if (pass && j == len - 1) begin
                for (int m = 0; m < 6; m++) begin
                    it.data = fr[len-6+m];
                    it.last = (m == 5);
                    it.user = (m == 5) ? user : 1'b0;
                    it.cyc  = edge_n + 1 + m;
                    q.push_back(it);
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge rx_clk);
            n++;
        end
        #1;
        chk(tag, 64'(q.size()), 64'd0);
        idle(3);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_passed"},  64'(frames_passed),  64'(exp_passed));
        chk({tag, "_dropped"}, 64'(frames_dropped), 64'(exp_dropped));
        chk({tag, "_runt"},    64'(frames_runt),    64'(exp_runt));
        chk({tag, "_ovl"},     64'(ovl_cnt),        64'(exp_ovl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rx_rst        = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        local_mac     = MY_MAC;
        promisc_en    = 1'b0;
        bcast_en      = 1'b0;
        mcast_en      = 1'b0;

        // Reset state
        repeat (3) @(posedge rx_clk);
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
        chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
        chk("rst_tuser",  64'(m_axis_tuser),  64'd0);
        chk("rst_ovl",    64'(overlap_err),   64'd0);
        chk_counters("rst");
        rx_rst = 1'b0;
        idle(2);

        // Unicast match, 64 bytes
        send_frame(MY_MAC, 64, 1'b0, 1'b1, -1);
        exp_passed++;
        drain("uni_drain");
        chk_counters("uni");

        // Address mismatch, then promiscuous
        send_frame(48'h02_00_00_00_00_02, 64, 1'b0, 1'b0, -1);
        exp_dropped++;
        idle(10);
        chk_counters("mismatch");
        promisc_en = 1'b1;
        send_frame(48'h02_00_00_00_00_02, 64, 1'b0, 1'b1, -1);
        exp_passed++;
        drain("promisc_drain");
        chk_counters("promisc");
        promisc_en = 1'b0;

        // Broadcast disabled / enabled
        send_frame(48'hFF_FF_FF_FF_FF_FF, 40, 1'b0, 1'b0, -1);
        exp_dropped++;
        idle(10);
        chk_counters("bcast_off");
        bcast_en = 1'b1;
        send_frame(48'hFF_FF_FF_FF_FF_FF, 40, 1'b0, 1'b1, -1);
        exp_passed++;
        drain("bcast_drain");
        chk_counters("bcast_on");
        bcast_en = 1'b0;

        // Multicast disabled / enabled
        send_frame(48'h01_00_5E_00_00_01, 30, 1'b0, 1'b0, -1);
        exp_dropped++;
        idle(10);
        chk_counters("mcast_off");
        mcast_en = 1'b1;
        send_frame(48'h01_00_5E_00_00_01, 30, 1'b0, 1'b1, -1);
        exp_passed++;
        drain("mcast_drain");
        chk_counters("mcast_on");
        mcast_en = 1'b0;

        // Runts: 4 bytes, 6 bytes; 7 bytes is the shortest passing frame
        send_frame(MY_MAC, 4, 1'b0, 1'b0, -1);
        exp_runt++;
        idle(10);
        chk_counters("runt4");
        send_frame(MY_MAC, 6, 1'b0, 1'b0, -1);
        exp_runt++;
        idle(10);
        chk_counters("runt6");
        send_frame(MY_MAC, 7, 1'b0, 1'b1, -1);
        exp_passed++;
        drain("len7_drain");
        chk_counters("len7");

        // Bad frame flag is carried on the final beat only
        send_frame(MY_MAC, 60, 1'b1, 1'b1, -1);
        exp_passed++;
        drain("tuser_drain");
        chk_counters("tuser");

        // Overlap: next frame starts two cycles after tlast
        send_frame(MY_MAC, 20, 1'b0, 1'b1, -1);
        exp_passed++;
        idle(1);
        send_frame(MY_MAC, 10, 1'b0, 1'b0, -1);
        exp_ovl++;
        drain("ovl_drain");
        chk_counters("overlap");
        idle(12);
        send_frame(MY_MAC, 64, 1'b0, 1'b1, -1);
        exp_passed++;
        drain("after_ovl_drain");
        chk_counters("after_ovl");

        // Reset in the middle of a forwarded frame
        send_frame(MY_MAC, 40, 1'b0, 1'b1, 20);
        #1;
        rx_rst = 1'b1;
        #1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_tdata",  64'(m_axis_tdata),  64'd0);
        chk("midrst_tlast",  64'(m_axis_tlast),  64'd0);
        chk("midrst_passed", 64'(frames_passed), 64'd0);
        chk("midrst_dropped",64'(frames_dropped),64'd0);
        chk("midrst_runt",   64'(frames_runt),   64'd0);
        q.delete();
        exp_passed  = 0;
        exp_dropped = 0;
        exp_runt    = 0;
        exp_ovl     = 0;
        ovl_cnt     = 0;
        repeat (2) @(posedge rx_clk);
        #1;
        rx_rst = 1'b0;
        idle(2);
        send_frame(MY_MAC, 30, 1'b0, 1'b1, -1);
        exp_passed++;
        drain("post_rst_drain");
        chk_counters("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
